// File: rtl/tpiu_sync_pkg.sv
// Shared constants and state type for the TPIU frame synchroniser.
// Referenced by tpiu_sync_detect and tpiu_frame_sync.
package tpiu_sync_pkg;

  localparam logic [3:0] SYNC_FILL = 4'hF;
  localparam logic [3:0] SYNC_END  = 4'h7;
  localparam logic [7:0] BYTE_FILL = 8'hFF;
  localparam logic [7:0] BYTE_END  = 8'h7F;

  localparam logic [2:0] FRUN_MAX = 3'd7;

  typedef enum logic {
    ST_UNSYNCED = 1'b0,
    ST_SYNCED   = 1'b1
  } sync_state_t;

endpackage

// File: rtl/tpiu_sync_detect.sv
// Counts consecutive 4'hF nibbles and flags a full sync (FF FF FF 7F).
// The run count is frozen while enable is low.
module tpiu_sync_detect
  import tpiu_sync_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] nibble,
  output logic       full_sync
);

  logic [2:0] frun_q;
  logic [2:0] frun_d;

  always_comb begin
    frun_d = frun_q;
    if (enable) begin
      if (nibble == SYNC_FILL) begin
        if (frun_q != FRUN_MAX) begin
          frun_d = frun_q + 3'd1;
        end
      end else begin
        frun_d = 3'd0;
      end
    end
  end

  // Compares against the count before this nibble updates it.
  assign full_sync = enable && (nibble == SYNC_END) && (frun_q == FRUN_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      frun_q <= 3'd0;
    end else begin
      frun_q <= frun_d;
    end
  end

endmodule

// File: rtl/tpiu_frame_sync.sv
// TPIU trace nibble-to-byte framer with full-sync alignment.
// Define TPIU_HALFSYNC_FILTER_EN to drop aligned FF,7F halfword-sync pairs.
//
// state       | meaning
// ST_UNSYNCED | no byte alignment, nibbles are discarded
// ST_SYNCED   | aligned, nibbles paired low-first into bytes
module tpiu_frame_sync
  import tpiu_sync_pkg::*;
#(
  parameter int pSYNC_CNT_WIDTH = 8
) (
  input  logic                       trace_clk,
  input  logic                       reset,
  input  logic [3:0]                 I_trace_data,
  input  logic                       I_enable,
  output logic [7:0]                 O_data,
  output logic                       O_data_valid,
  output logic                       O_synced,
  output logic                       O_resync,
  output logic [pSYNC_CNT_WIDTH-1:0] O_sync_count
);

  localparam logic [pSYNC_CNT_WIDTH-1:0] CNT_ONE = {{(pSYNC_CNT_WIDTH-1){1'b0}}, 1'b1};

  sync_state_t                state_q, state_d;
  logic                       phase_q, phase_d;
  logic [3:0]                 low_q, low_d;
  logic [pSYNC_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]                 data_q, data_d;
  logic                       vld_q, vld_d;
  logic                       resync_q, resync_d;

  logic                       full_sync;
  logic                       byte_v;
  logic [7:0]                 byte_b;

`ifdef TPIU_HALFSYNC_FILTER_EN
  logic                       held_q, held_d;
  logic                       pend_v_q, pend_v_d;
  logic [7:0]                 pend_q, pend_d;
`endif

  tpiu_sync_detect u_detect (
    .clk       (trace_clk),
    .reset     (reset),
    .enable    (I_enable),
    .nibble    (I_trace_data),
    .full_sync (full_sync)
  );

  // Alignment FSM and nibble pairing; phase_q high means a low nibble is held.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    low_d    = low_q;
    cnt_d    = cnt_q;
    resync_d = 1'b0;
    byte_v   = 1'b0;
    byte_b   = {I_trace_data, low_q};

    if (!I_enable) begin
      state_d = ST_UNSYNCED;
      phase_d = 1'b0;
    end else if (full_sync) begin
      state_d = ST_SYNCED;
      phase_d = 1'b0;
      if (cnt_q != {pSYNC_CNT_WIDTH{1'b1}}) begin
        cnt_d = cnt_q + CNT_ONE;
      end
      if (state_q == ST_SYNCED) begin
        if (phase_q) begin
          byte_v = 1'b1;
        end else begin
          resync_d = 1'b1;
        end
      end
    end else if (state_q == ST_SYNCED) begin
      if (!phase_q) begin
        low_d   = I_trace_data;
        phase_d = 1'b1;
      end else begin
        byte_v  = 1'b1;
        phase_d = 1'b0;
      end
    end
  end

`ifdef TPIU_HALFSYNC_FILTER_EN
  // An FF is held until the following byte shows whether it starts a halfword sync.
  always_comb begin
    data_d   = data_q;
    vld_d    = 1'b0;
    held_d   = held_q;
    pend_v_d = 1'b0;
    pend_d   = pend_q;

    if (pend_v_q && I_enable) begin
      vld_d  = 1'b1;
      data_d = pend_q;
    end

    if (!I_enable || resync_d) begin
      held_d = 1'b0;
    end

    if (byte_v) begin
      if (held_q) begin
        if (byte_b == BYTE_END) begin
          held_d = 1'b0;
        end else if (byte_b == BYTE_FILL) begin
          vld_d  = 1'b1;
          data_d = BYTE_FILL;
        end else begin
          vld_d    = 1'b1;
          data_d   = BYTE_FILL;
          held_d   = 1'b0;
          pend_v_d = 1'b1;
          pend_d   = byte_b;
        end
      end else if (byte_b == BYTE_FILL) begin
        held_d = 1'b1;
      end else begin
        vld_d  = 1'b1;
        data_d = byte_b;
      end
    end
  end
`else
  always_comb begin
    data_d = data_q;
    vld_d  = 1'b0;
    if (byte_v) begin
      vld_d  = 1'b1;
      data_d = byte_b;
    end
  end
`endif

  always_ff @(posedge trace_clk) begin
    if (reset) begin
      state_q  <= ST_UNSYNCED;
      phase_q  <= 1'b0;
      low_q    <= 4'h0;
      cnt_q    <= '0;
      data_q   <= 8'h00;
      vld_q    <= 1'b0;
      resync_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      low_q    <= low_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      resync_q <= resync_d;
    end
  end

`ifdef TPIU_HALFSYNC_FILTER_EN
  always_ff @(posedge trace_clk) begin
    if (reset) begin
      held_q   <= 1'b0;
      pend_v_q <= 1'b0;
      pend_q   <= 8'h00;
    end else begin
      held_q   <= held_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
    end
  end
`endif

  assign O_data       = data_q;
  assign O_data_valid = vld_q;
  assign O_synced     = (state_q == ST_SYNCED);
  assign O_resync     = resync_q;
  assign O_sync_count = cnt_q;

endmodule

// File: tb/tb_tpiu_frame_sync.sv
// Scoreboard bench for tpiu_frame_sync: a queue-based reference model predicts
// bytes, resync pulses and status; a negedge monitor compares them.
module tb_tpiu_frame_sync;

  localparam int W    = 8;
  localparam int CMAX = (1 << W) - 1;

  logic           trace_clk = 1'b0;
  logic           reset = 1'b1;
  logic [3:0]     I_trace_data = 4'h0;
  logic           I_enable = 1'b0;
  logic [7:0]     O_data;
  logic           O_data_valid;
  logic           O_synced;
  logic           O_resync;
  logic [W-1:0]   O_sync_count;

  tpiu_frame_sync #(.pSYNC_CNT_WIDTH(W)) dut (
    .trace_clk    (trace_clk),
    .reset        (reset),
    .I_trace_data (I_trace_data),
    .I_enable     (I_enable),
    .O_data       (O_data),
    .O_data_valid (O_data_valid),
    .O_synced     (O_synced),
    .O_resync     (O_resync),
    .O_sync_count (O_sync_count)
  );

  always #5 trace_clk = ~trace_clk;

  int cyc = 0;
  always @(posedge trace_clk) cyc <= cyc + 1;

  typedef struct {int tag; logic [7:0] b;} byte_exp_t;
  typedef struct {int tag; bit synced; int count; bit zero;} stat_exp_t;

  byte_exp_t bq[$];
  int        rq[$];
  stat_exp_t sq[$];

  int checks   = 0;
  int failures = 0;
  bit armed    = 0;

  // Reference model: history of consumed nibbles and nibbles since alignment.
  bit         m_synced = 0;
  int         m_count  = 0;
  logic [3:0] m_hist[$];
  logic [3:0] m_nq[$];
  bit         m_held = 0;
  bit         m_pv   = 0;
  logic [7:0] m_pb   = 8'h00;

  function automatic bit all_fill();
    if (m_hist.size() < 7) return 1'b0;
    foreach (m_hist[i]) if (m_hist[i] != 4'hF) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_byte(input logic [7:0] b, input int t);
    byte_exp_t e;
    e.tag = t;
    e.b   = b;
    bq.push_back(e);
  endtask

  task automatic aligned_byte(input logic [7:0] b, input int t);
`ifdef TPIU_HALFSYNC_FILTER_EN
    if (m_held) begin
      if (b == 8'h7F) m_held = 0;
      else if (b == 8'hFF) push_byte(8'hFF, t);
      else begin
        push_byte(8'hFF, t);
        m_held = 0;
        m_pv   = 1;
        m_pb   = b;
      end
    end else if (b == 8'hFF) m_held = 1;
    else push_byte(b, t);
`else
    push_byte(b, t);
`endif
  endtask

  task automatic model_step(input logic [3:0] n, input bit e, input bit r, input int t);
    stat_exp_t s;
    bit        full;
    if (m_pv) begin
      if (!r && e) push_byte(m_pb, t);
      m_pv = 0;
    end
    s.tag  = t;
    s.zero = 0;
    if (r) begin
      m_hist.delete();
      m_nq.delete();
      m_synced = 0;
      m_count  = 0;
      m_held   = 0;
      s.zero   = 1;
    end else if (!e) begin
      m_synced = 0;
      m_held   = 0;
    end else begin
      full = (n == 4'h7) && all_fill();
      m_hist.push_back(n);
      if (m_hist.size() > 7) void'(m_hist.pop_front());
      if (full) begin
        if (m_count < CMAX) m_count++;
        if (m_synced) begin
          if (m_nq.size() == 1) aligned_byte({n, m_nq[0]}, t);
          else begin
            rq.push_back(t);
            m_held = 0;
          end
        end
        m_nq.delete();
        m_synced = 1;
      end else if (m_synced) begin
        m_nq.push_back(n);
        if (m_nq.size() == 2) begin
          aligned_byte({m_nq[1], m_nq[0]}, t);
          m_nq.delete();
        end
      end
    end
    s.synced = m_synced;
    s.count  = m_count;
    sq.push_back(s);
  endtask

  task automatic step(input logic [3:0] n, input bit e = 1, input bit r = 0);
    @(negedge trace_clk);
    I_trace_data = n;
    I_enable     = e;
    reset        = r;
    model_step(n, e, r, cyc + 1);
  endtask

  task automatic full_sync_seq();
    repeat (7) step(4'hF);
    step(4'h7);
  endtask

  task automatic pair(input logic [3:0] lo, input logic [3:0] hi);
    step(lo);
    step(hi);
  endtask

  // Monitor: compares DUT outputs against whatever the model queued for this cycle.
  always @(negedge trace_clk) begin
    bit exp_v;
    bit exp_r;
    while (bq.size() > 0 && bq[0].tag < cyc) void'(bq.pop_front());
    while (rq.size() > 0 && rq[0] < cyc) void'(rq.pop_front());
    exp_v = (bq.size() > 0 && bq[0].tag == cyc);
    exp_r = (rq.size() > 0 && rq[0] == cyc);
    if (armed) begin
      checks++;
      if (O_data_valid !== exp_v) begin
        failures++;
        $display("FAIL strobe cyc=%0d got=%b exp=%b", cyc, O_data_valid, exp_v);
      end
      if (exp_v && O_data_valid === 1'b1) begin
        checks++;
        if (O_data !== bq[0].b) begin
          failures++;
          $display("FAIL data cyc=%0d got=%h exp=%h", cyc, O_data, bq[0].b);
        end
      end
      checks++;
      if (O_resync !== exp_r) begin
        failures++;
        $display("FAIL resync cyc=%0d got=%b exp=%b", cyc, O_resync, exp_r);
      end
    end
    if (exp_v) void'(bq.pop_front());
    if (exp_r) void'(rq.pop_front());
    while (sq.size() > 0 && sq[0].tag <= cyc) begin
      if (armed && sq[0].tag == cyc) begin
        checks++;
        if (O_synced !== sq[0].synced) begin
          failures++;
          $display("FAIL synced cyc=%0d got=%b exp=%b", cyc, O_synced, sq[0].synced);
        end
        checks++;
        if (int'(O_sync_count) != sq[0].count) begin
          failures++;
          $display("FAIL sync_count cyc=%0d got=%0d exp=%0d", cyc, O_sync_count, sq[0].count);
        end
        if (sq[0].zero) begin
          checks++;
          if (O_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data cyc=%0d got=%h exp=00", cyc, O_data);
          end
        end
      end
      void'(sq.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    step(4'h0, 1, 1);
    step(4'h0, 1, 1);
    armed = 1;

    // Acquire sync, then 4,1 -> 8'h14
    full_sync_seq();
    pair(4'h4, 4'h1);

    // Aligned full sync while synced
    full_sync_seq();
    pair(4'h5, 4'hA);

    // Halfword-sync pair followed by FF,55
    pair(4'hF, 4'hF);
    pair(4'hF, 4'h7);
    pair(4'hF, 4'hF);
    pair(4'h5, 4'h5);

    // Misaligned by one nibble, then full sync forces realignment
    step(4'h3);
    full_sync_seq();
    pair(4'h2, 4'hA);

    // Reset between low and high nibble
    step(4'h4);
    step(4'h9, 1, 1);
    pair(4'h1, 4'h2);
    pair(4'hF, 4'hF);
    full_sync_seq();
    pair(4'hC, 4'h3);

    // Enable low mid-byte drops sync
    step(4'h6);
    step(4'h0, 0, 0);
    step(4'h0, 0, 0);
    pair(4'h8, 4'h8);
    full_sync_seq();
    pair(4'hF, 4'hF);
    step(4'h0, 0, 0);
    pair(4'h1, 4'h1);

    // Counter saturation
    repeat (300) full_sync_seq();
    pair(4'hE, 4'hD);

    // Randomized stream biased toward sync nibbles
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0) step(4'($urandom_range(0, 15)), 1, 1);
      else if (r < 5) step(4'h0, 0, 0);
      else if (r < 8) full_sync_seq();
      else if (r < 110) step(4'hF);
      else if (r < 140) step(4'h7);
      else step(4'($urandom_range(0, 15)));
    end

    step(4'h0, 0, 0);
    repeat (4) @(negedge trace_clk);
    checks++;
    if (bq.size() != 0) begin
      failures++;
      $display("FAIL byte_queue_drain left=%0d exp=0", bq.size());
    end
    checks++;
    if (rq.size() != 0) begin
      failures++;
      $display("FAIL resync_queue_drain left=%0d exp=0", rq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
